demux4_stream: RTL and testbench

DEMUX4_STREAM -- requirements
Module: demux4_stream

---
 rtl/demux4_stream.sv | 83 ++++++++
 tb/tb_demux4_stream.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/demux4_stream.sv
// demux4_stream: routes one input stream word to one of four single-entry
// output lanes, either by an explicit destination or round-robin.
//
// Ports:
//   clk, reset          clock and synchronous active-low reset
//   in_valid, in_data   upstream word
//   in_dest             destination lane when rr_mode==0
//   rr_mode             0 = directed by in_dest, 1 = round-robin by rr_ptr
//   in_ready            combinational: the targeted lane can take a word now
//   out_valid[i]        lane i holds a word
//   out_data            lane i at bits [i*WIDTH +: WIDTH]
//   out_ready[i]        lane i consumer takes the word
//   rr_ptr              next round-robin target lane
//   accept_count        total accepted words (wraps at 16 bits)
module demux4_stream #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [1:0]           in_dest,
  input  logic                 rr_mode,
  output logic                 in_ready,
  output logic [3:0]           out_valid,
  output logic [4*WIDTH-1:0]   out_data,
  input  logic [3:0]           out_ready,
  output logic [1:0]           rr_ptr,
  output logic [15:0]          accept_count
);

  localparam int unsigned NLANES = 4;

  logic [NLANES-1:0] full;
  logic [WIDTH-1:0]  data [NLANES];
  logic [1:0]        tgt;
  logic              accept;

  // Target lane selection and acceptance; in_ready never looks at in_valid.
  always_comb begin
    tgt      = rr_mode ? rr_ptr : in_dest;
    in_ready = !full[tgt] || out_ready[tgt];
    accept   = in_valid && in_ready;
  end

  // Lane registers, round-robin pointer and accept counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      full         <= '0;
      rr_ptr       <= 2'd0;
      accept_count <= 16'd0;
      for (int i = 0; i < NLANES; i++) begin
        data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NLANES; i++) begin
        // A load wins over a drain so a same-edge drain+load keeps the lane full.
        if (accept && (tgt == 2'(i))) begin
          full[i] <= 1'b1;
          data[i] <= in_data;
        end else if (full[i] && out_ready[i]) begin
          full[i] <= 1'b0;
        end
      end
      if (accept) begin
        accept_count <= accept_count + 16'd1;
        if (rr_mode) begin
          rr_ptr <= rr_ptr + 2'd1;
        end
      end
    end
  end

  // Lane state drives the outputs directly.
  always_comb begin
    out_valid = full;
    out_data  = '0;
    for (int i = 0; i < NLANES; i++) begin
      out_data[i*WIDTH +: WIDTH] = data[i];
    end
  end

endmodule

// File: tb/tb_demux4_stream.sv
// Directed testbench for demux4_stream.
module tb_demux4_stream;

  localparam int unsigned WIDTH = 8;

  logic               clk;
  logic               reset;
  logic               in_valid;
  logic [WIDTH-1:0]   in_data;
  logic [1:0]         in_dest;
  logic               rr_mode;
  logic               in_ready;
  logic [3:0]         out_valid;
  logic [4*WIDTH-1:0] out_data;
  logic [3:0]         out_ready;
  logic [1:0]         rr_ptr;
  logic [15:0]        accept_count;

  int errors = 0;
  int checks = 0;

  demux4_stream #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_dest      (in_dest),
    .rr_mode      (rr_mode),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .rr_ptr       (rr_ptr),
    .accept_count (accept_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    in_valid = 1'b0;
    cyc();
    reset = 1'b1;
  endtask

  function automatic logic [WIDTH-1:0] lane(input int i);
    return out_data[i*WIDTH +: WIDTH];
  endfunction

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_dest   = 2'd0;
    rr_mode   = 1'b0;
    out_ready = 4'b0000;
    cyc();
    cyc();

    // Reset state
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_rr_ptr", 32'(rr_ptr), 32'h0);
    check("rst_count", 32'(accept_count), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    reset = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'h1);

    // Directed routing, back-to-back
    do_reset();
    rr_mode   = 1'b0;
    out_ready = 4'b1111;
    in_valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data = 8'hA0 + 8'(k);
      in_dest = 2'(3 - k);
      #1;
      check("dir_in_ready", 32'(in_ready), 32'h1);
      cyc();
      check("dir_out_valid", 32'(out_valid), 32'(4'b0001 << (3 - k)));
      check("dir_lane_data", 32'(lane(3 - k)), 32'(8'hA0 + 8'(k)));
    end
    in_valid = 1'b0;
    check("dir_count", 32'(accept_count), 32'd4);
    check("dir_rr_hold", 32'(rr_ptr), 32'd0);
    cyc();
    check("dir_drained", 32'(out_valid), 32'h0);

    // Round-robin with wrap
    do_reset();
    rr_mode   = 1'b1;
    out_ready = 4'b1111;
    in_valid  = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_data = 8'h10 + 8'(k);
      in_dest = 2'd3;
      #1;
      check("rr_ptr_before", 32'(rr_ptr), 32'(k % 4));
      cyc();
      check("rr_out_valid", 32'(out_valid), 32'(4'b0001 << (k % 4)));
      check("rr_lane_data", 32'(lane(k % 4)), 32'(8'h10 + 8'(k)));
    end
    in_valid = 1'b0;
    check("rr_ptr_end", 32'(rr_ptr), 32'd2);
    check("rr_count", 32'(accept_count), 32'd6);

    // Backpressure and same-edge drain+load
    do_reset();
    rr_mode   = 1'b0;
    out_ready = 4'b0000;
    in_dest   = 2'd1;
    in_valid  = 1'b1;
    in_data   = 8'h55;
    #1;
    check("bp_ready_first", 32'(in_ready), 32'h1);
    cyc();
    in_data = 8'h66;
    #1;
    check("bp_ready_blocked", 32'(in_ready), 32'h0);
    cyc();
    check("bp_held_valid", 32'(out_valid), 32'b0010);
    check("bp_held_data", 32'(lane(1)), 32'h55);
    check("bp_count_held", 32'(accept_count), 32'd1);
    out_ready = 4'b0010;
    #1;
    check("bp_ready_release", 32'(in_ready), 32'h1);
    cyc();
    in_valid = 1'b0;
    check("bp_swap_valid", 32'(out_valid), 32'b0010);
    check("bp_swap_data", 32'(lane(1)), 32'h66);
    check("bp_count", 32'(accept_count), 32'd2);
    cyc();
    check("bp_drained", 32'(out_valid), 32'h0);
    in_valid = 1'b1;
    in_valid = 1'b0;
    #1;
    check("bp_ready_no_valid", 32'(in_ready), 32'h1);

    // Lane independence
    do_reset();
    out_ready = 4'b0000;
    rr_mode   = 1'b0;
    in_valid  = 1'b1;
    in_dest   = 2'd2;
    in_data   = 8'h99;
    cyc();
    #1;
    check("ind_lane2_blocks", 32'(in_ready), 32'h0);
    in_dest = 2'd0;
    in_data = 8'h77;
    #1;
    check("ind_lane0_ready", 32'(in_ready), 32'h1);
    cyc();
    in_valid = 1'b0;
    check("ind_out_valid", 32'(out_valid), 32'b0101);
    check("ind_lane0", 32'(lane(0)), 32'h77);
    check("ind_lane2", 32'(lane(2)), 32'h99);

    // Reset mid-stream
    do_reset();
    out_ready = 4'b0110;
    rr_mode   = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = 8'hC0 + 8'(k);
      cyc();
    end
    rr_mode = 1'b0;
    in_dest = 2'd3;
    in_data = 8'hC3;
    cyc();
    check("mid_rr_switch_hold", 32'(rr_ptr), 32'd3);
    in_dest = 2'd1;
    in_data = 8'hC4;
    cyc();
    in_valid = 1'b0;
    cyc();
    check("mid_pre_valid", 32'(out_valid), 32'b1001);
    check("mid_pre_count", 32'(accept_count), 32'd5);
    check("mid_pre_rr", 32'(rr_ptr), 32'd3);
    check("mid_pre_lane0", 32'(lane(0)), 32'hC0);
    reset    = 1'b0;
    in_valid = 1'b1;
    in_dest  = 2'd1;
    in_data  = 8'hEE;
    cyc();
    check("mid_valid", 32'(out_valid), 32'h0);
    check("mid_data", 32'(out_data), 32'h0);
    check("mid_rr", 32'(rr_ptr), 32'd0);
    check("mid_count", 32'(accept_count), 32'd0);
    in_valid = 1'b0;
    reset    = 1'b1;
    cyc();
    check("mid_nothing_loaded", 32'(out_valid), 32'h0);

    // Counter wrap
    do_reset();
    rr_mode   = 1'b0;
    out_ready = 4'b1111;
    in_dest   = 2'd0;
    in_data   = 8'h3C;
    in_valid  = 1'b1;
    repeat (65535) cyc();
    check("wrap_ffff", 32'(accept_count), 32'hFFFF);
    cyc();
    in_valid = 1'b0;
    check("wrap_zero", 32'(accept_count), 32'h0);
    check("wrap_lane0", 32'(out_valid), 32'b0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
